// File: rtl/x_encoder.sv
// x_encoder -- depth-3 binary decision-tree quantiser over three binary32 values.
//
// Ports:
//   clock  in   1   rising-edge clock
//   reset  in   1   synchronous, active-high; forces x_enc to 3'b000
//   x      in  96   {x0, x1, x2}, each IEEE-754 binary32 (x0 in the top word)
//   x_enc  out  3   registered code {bit2, bit1, bit0}, one clock after x
//
// Tree:
//   bit2 = x0 > SV1
//   bit1 = x1 > (bit2 ? SV2_1 : SV2_0)
//   bit0 = x2 > SV3_{bit2,bit1}
// Every candidate comparison at levels 2 and 3 is evaluated in parallel.
// The earlier tree bits then only drive a small mux.
// This keeps the path short: one comparator plus two mux levels, not three
// comparators in series.

// ---------------------------------------------------------------------------
// x_encoder_fgt -- combinational IEEE-754 binary32 ordered greater-than.
//
// Ports:
//   a, b  in   W   binary32 operands
//   gt    out  1   1 iff a > b (strict, ordered); 0 if either is NaN
//
// Uses sign/magnitude ordering of the raw encodings.
// Among positive values, a larger {exp,mant} field means a larger number.
// Among negative values, the ordering reverses.
// Subnormals and infinities fall out of the raw-field ordering without
// special handling. Only NaN and the +0/-0 pair need explicit treatment.
// ---------------------------------------------------------------------------
module x_encoder_fgt #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt
);
  localparam int EW = 8;
  localparam int MW = W - EW - 1;

  logic         a_sign, b_sign;
  logic [W-2:0] a_mag,  b_mag;
  logic         a_nan,  b_nan;
  logic         both_zero;

  assign a_sign = a[W-1];
  assign b_sign = b[W-1];
  assign a_mag  = a[W-2:0];
  assign b_mag  = b[W-2:0];

  // NaN: all-ones exponent with a non-zero fraction.
  assign a_nan = (&a[W-2:MW]) && (|a[MW-1:0]);
  assign b_nan = (&b[W-2:MW]) && (|b[MW-1:0]);

  // +0 and -0 are equal whatever their signs.
  assign both_zero = (a_mag == '0) && (b_mag == '0);

  always_comb begin
    gt = 1'b0;
    if (a_nan || b_nan) begin
      gt = 1'b0;
    end else if (both_zero) begin
      gt = 1'b0;
    end else if (a_sign != b_sign) begin
      // Mixed signs: the positive operand wins. This also covers +0 against a
      // negative value, and -0 against a positive one.
      gt = ~a_sign;
    end else if (!a_sign) begin
      gt = (a_mag > b_mag);
    end else begin
      gt = (a_mag < b_mag);
    end
  end
endmodule

// ---------------------------------------------------------------------------
// x_encoder -- top level.
// ---------------------------------------------------------------------------
module x_encoder #(
  parameter int                    DTYPE_SIZE = 32,
  parameter logic [DTYPE_SIZE-1:0] SV1        = 32'hBE818C7E,
  parameter logic [DTYPE_SIZE-1:0] SV2_0      = 32'hBF2A98A4,
  parameter logic [DTYPE_SIZE-1:0] SV2_1      = 32'hBE9D3148,
  parameter logic [DTYPE_SIZE-1:0] SV3_0      = 32'hBEF51B60,
  parameter logic [DTYPE_SIZE-1:0] SV3_1      = 32'h3E9AE4A0,
  parameter logic [DTYPE_SIZE-1:0] SV3_2      = 32'h3F0D7250,
  parameter logic [DTYPE_SIZE-1:0] SV3_3      = 32'h3EFAE4A0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [3*DTYPE_SIZE-1:0]   x,
  output logic [2:0]                x_enc
);
  // Per-level threshold tables, indexed by the tree path taken so far.
  localparam logic [1:0][DTYPE_SIZE-1:0] SV2_TAB = {SV2_1, SV2_0};
  localparam logic [3:0][DTYPE_SIZE-1:0] SV3_TAB = {SV3_3, SV3_2, SV3_1, SV3_0};

  logic [DTYPE_SIZE-1:0] x0, x1, x2;
  logic                  gt1;
  logic [1:0]            gt2;
  logic [3:0]            gt3;
  logic                  bit2, bit1, bit0;
  logic [2:0]            enc;

  assign x0 = x[3*DTYPE_SIZE-1:2*DTYPE_SIZE];
  assign x1 = x[2*DTYPE_SIZE-1:DTYPE_SIZE];
  assign x2 = x[DTYPE_SIZE-1:0];

  // Level 1: single split on x0.
  x_encoder_fgt #(.W(DTYPE_SIZE)) u_lvl1 (
    .a  (x0),
    .b  (SV1),
    .gt (gt1)
  );

  // Level 2: both candidate splits on x1.
  for (genvar i = 0; i < 2; i++) begin : g_lvl2
    x_encoder_fgt #(.W(DTYPE_SIZE)) u_cmp (
      .a  (x1),
      .b  (SV2_TAB[i]),
      .gt (gt2[i])
    );
  end

  // Level 3: all four candidate splits on x2.
  for (genvar j = 0; j < 4; j++) begin : g_lvl3
    x_encoder_fgt #(.W(DTYPE_SIZE)) u_cmp (
      .a  (x2),
      .b  (SV3_TAB[j]),
      .gt (gt3[j])
    );
  end

  // Walk the tree: each level's result selects among the next level's
  // precomputed comparisons.
  assign bit2 = gt1;
  assign bit1 = gt2[bit2];
  assign bit0 = gt3[{bit2, bit1}];
  assign enc  = {bit2, bit1, bit0};

  always_ff @(posedge clock) begin
    if (reset) x_enc <= 3'b000;
    else       x_enc <= enc;
  end
endmodule

// File: tb/tb_x_encoder.sv
// tb_x_encoder -- self-checking bench for x_encoder.
// Reference model: operands are decoded to real numbers and compared with the
// real ">" operator; NaN is detected from the encoding and forces 0.
module tb_x_encoder;
  localparam logic [31:0] SV1   = 32'hBE818C7E;
  localparam logic [31:0] SV2_0 = 32'hBF2A98A4;
  localparam logic [31:0] SV2_1 = 32'hBE9D3148;
  localparam logic [31:0] SV3_0 = 32'hBEF51B60;
  localparam logic [31:0] SV3_1 = 32'h3E9AE4A0;
  localparam logic [31:0] SV3_2 = 32'h3F0D7250;
  localparam logic [31:0] SV3_3 = 32'h3EFAE4A0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [95:0] x     = '0;
  logic [2:0]  x_enc;

  int passed = 0;
  int total  = 0;

  x_encoder dut (
    .clock (clock),
    .reset (reset),
    .x     (x),
    .x_enc (x_enc)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic bit is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 0);
  endfunction

  function automatic real to_real(input logic [31:0] f);
    real mag;
    int  e;
    e = int'(f[30:23]);
    if (e == 255)    mag = 1.0e300;                           // infinity
    else if (e == 0) mag = real'(f[22:0]) * (2.0 ** (-149));  // zero / subnormal
    else             mag = real'({1'b1, f[22:0]}) * (2.0 ** (e - 150));
    return f[31] ? -mag : mag;
  endfunction

  function automatic bit f_gt(input logic [31:0] a, input logic [31:0] b);
    if (is_nan(a) || is_nan(b)) return 1'b0;
    return to_real(a) > to_real(b);
  endfunction

  function automatic logic [2:0] model(input logic [95:0] v);
    logic [31:0] t2, t3;
    bit b2, b1, b0;
    b2 = f_gt(v[95:64], SV1);
    t2 = b2 ? SV2_1 : SV2_0;
    b1 = f_gt(v[63:32], t2);
    case ({b2, b1})
      2'b00:   t3 = SV3_0;
      2'b01:   t3 = SV3_1;
      2'b10:   t3 = SV3_2;
      default: t3 = SV3_3;
    endcase
    b0 = f_gt(v[31:0], t3);
    return {b2, b1, b0};
  endfunction

  function automatic logic [31:0] rand_f();
    logic [31:0] r;
    logic [31:0] th [7];
    th = '{SV1, SV2_0, SV2_1, SV3_0, SV3_1, SV3_2, SV3_3};
    r = $urandom;
    case ($urandom_range(0, 9))
      0: r = {r[31], 31'h0};                                  // +/-0
      1: r = {r[31], 8'hFF, 23'h0};                           // +/-Inf
      2: r = {r[31], 8'hFF, r[22:1], 1'b1};                   // NaN
      3: r = {r[31], 8'h00, r[22:0]};                         // subnormal
      4: r = th[$urandom_range(0, 6)];                        // exact tie
      5: begin
        r = th[$urandom_range(0, 6)];
        r = r[0] ? r - 32'd1 : r + 32'd1;                     // one ulp away
      end
      default: r = {r[31], 8'(118 + $urandom_range(0, 10)), r[22:0]};
    endcase
    return r;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      x = {$urandom, $urandom, $urandom};
      @(posedge clock); #1;
      total++;
      if (x_enc !== 3'b000) $display("FAIL reset_%0d: got %b want 000", i, x_enc);
      else passed++;
    end
    // Reset takes priority over a vector that would encode to 111.
    x = {32'h3E82A86F, 32'hBDADE3D8, 32'h3FB6CED8};
    @(posedge clock); #1;
    total++;
    if (x_enc !== 3'b000) $display("FAIL reset_priority: got %b want 000", x_enc);
    else passed++;
    reset = 1'b0;
    @(posedge clock); #1;
    total++;
    if (x_enc !== 3'b111) $display("FAIL first_after_reset: got %b want 111", x_enc);
    else passed++;
  endtask

  task automatic test_hold();
    // Input changes between edges must not disturb the registered code.
    x = {32'hBF800000, 32'hBF800000, 32'hBF800000};
    #3;
    total++;
    if (x_enc !== 3'b111) $display("FAIL hold: got %b want 111", x_enc);
    else passed++;
    @(posedge clock); #1;
    total++;
    if (x_enc !== 3'b000) $display("FAIL hold_update: got %b want 000", x_enc);
    else passed++;
  endtask

  task automatic test_directed();
    logic [95:0] vec [4];
    logic [2:0]  exp [4];
    vec = '{{32'h3E82A86F, 32'hBDADE3D8, 32'h3E82A86F},
            {32'hBF800000, 32'hBF800000, 32'hBF800000},
            {32'hBE818C7E, 32'hBF2A98A4, 32'h3F800000},
            {32'h7FC00000, 32'h00000000, 32'h80000000}};
    exp = '{3'b110, 3'b000, 3'b001, 3'b010};
    for (int i = 0; i < 4; i++) begin
      x = vec[i];
      @(posedge clock); #1;
      total++;
      if (x_enc !== exp[i]) $display("FAIL directed_%0d: got %b want %b", i, x_enc, exp[i]);
      else passed++;
      total++;
      if (model(vec[i]) !== exp[i]) $display("FAIL model_%0d: got %b want %b", i, model(vec[i]), exp[i]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [95:0] vec [5];
    logic [2:0]  exp [5];
    vec = '{{32'h3E82A86F, 32'hBDADE3D8, 32'h3FB6CED8},
            {32'h3E82A86F, 32'hBDADE3D8, 32'h3E82A86F},
            {32'hBF800000, 32'hBF800000, 32'hBF800000},
            {32'hBE818C7E, 32'hBF2A98A4, 32'h3F800000},
            {32'h3E82A86F, 32'hBDADE3D8, 32'h3FB6CED8}};
    exp = '{3'b111, 3'b110, 3'b000, 3'b001, 3'b000};
    for (int i = 0; i < 5; i++) begin
      x = vec[i];
      reset = (i == 4);       // reset lands mid-stream on the last vector
      @(posedge clock); #1;
      total++;
      if (x_enc !== exp[i]) $display("FAIL b2b_%0d: got %b want %b", i, x_enc, exp[i]);
      else passed++;
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [95:0] v;
    logic [2:0]  e;
    int          errs = 0;
    for (int i = 0; i < 400; i++) begin
      v = {rand_f(), rand_f(), rand_f()};
      x = v;
      reset = ($urandom_range(0, 39) == 0);
      e = reset ? 3'b000 : model(v);
      @(posedge clock); #1;
      total++;
      if (x_enc !== e) begin
        if (errs < 10) $display("FAIL random_%0d x=%h: got %b want %b", i, v, x_enc, e);
        errs++;
      end else passed++;
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hold();
    test_directed();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/x_encoder.md
X_ENCODER -- requirements
Module: x_encoder

Interface
REQ-001 Parameter DTYPE_SIZE, default 32, width in bits of each IEEE-754 binary32 operand; only 32 is supported.
REQ-002 Parameter SV1, default 32'hBE818C7E (~-0.2530), level-1 split threshold.
REQ-003 Parameter SV2_0, default 32'hBF2A98A4 (~-0.6664), level-2 threshold used when bit2=0.
REQ-004 Parameter SV2_1, default 32'hBE9D3148 (~-0.3070), level-2 threshold used when bit2=1.
REQ-005 Parameter SV3_0, default 32'hBEF51B60 (~-0.4787), level-3 threshold used when {bit2,bit1}=00.
REQ-006 Parameter SV3_1, default 32'h3E9AE4A0 (~+0.3025), level-3 threshold used when {bit2,bit1}=01.
REQ-007 Parameter SV3_2, default 32'h3F0D7250 (~+0.5525), level-3 threshold used when {bit2,bit1}=10.
REQ-008 Parameter SV3_3, default 32'h3EFAE4A0 (~+0.4900), level-3 threshold used when {bit2,bit1}=11.
REQ-009 Port order: clock, reset, x, x_enc.
REQ-010 Port clock: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-011 Port reset: input, 1 bit; reset is synchronous and active-high.
REQ-012 Port x: input, 96 bits; x[95:64]=x0, x[63:32]=x1, x[31:0]=x2, each IEEE-754 binary32.
REQ-013 Port x_enc: output, 3 bits, registered tree-quantiser code {bit2,bit1,bit0}.

Function
REQ-014 The block SHALL implement a depth-3 binary decision tree over x0, x1, x2.
REQ-015 bit2 SHALL be 1 iff x0 > SV1.
REQ-016 bit1 SHALL be 1 iff x1 > (bit2 ? SV2_1 : SV2_0).
REQ-017 bit0 SHALL be 1 iff x2 > SV3_{2*bit2+bit1}.
REQ-018 The comparison ">" SHALL be strict IEEE-754 ordered greater-than; equality yields 0.
REQ-019 +0 and -0 SHALL compare equal.
REQ-020 If either operand is NaN, the comparison SHALL yield 0.
REQ-021 Infinities SHALL be ordered normally; subnormals SHALL be compared exactly, with no flush-to-zero.
REQ-022 The comparator SHALL be a reusable combinational float-greater-than submodule using sign/magnitude ordering: both signs positive compares magnitude ascending; both negative compares magnitude descending; mixed signs means positive > negative unless both are zero.
REQ-023 All three tree levels SHALL be evaluated combinationally from the same x sample.
REQ-024 x_enc SHALL be registered: latency is exactly 1 clock from x to x_enc.
REQ-025 A new x SHALL be accepted every cycle (throughput 1 per clock); there is no handshake.
REQ-026 x_enc SHALL hold its value between rising edges regardless of x changes.

Reset
REQ-027 While reset=1 at a rising edge, x_enc SHALL load 3'b000.
REQ-028 Reset SHALL take priority over the encode update on the same edge.
REQ-029 On the first rising edge with reset=0, x_enc SHALL take the encoding of x sampled at that edge.
REQ-030 The initial x_enc value before the first reset SHALL be treated as undefined.

Verification
REQ-031 Assert reset for 2 clocks with any x -> x_enc=000; deassert with x={3E82A86F,BDADE3D8,3FB6CED8} -> x_enc=111 after the next edge.
REQ-032 x={3E82A86F,BDADE3D8,3E82A86F} -> x_enc=110 one clock later; x={BF800000,BF800000,BF800000} -> 000.
REQ-033 Tie case: x={BE818C7E,BF2A98A4,3F800000} (x0=SV1, x1=SV2_0) -> x_enc=001.
REQ-034 NaN/zero case: x={7FC00000,00000000,80000000} -> x_enc=010.
REQ-035 Back-to-back vectors on consecutive clocks (REQ-031, REQ-032, REQ-033 values) -> each x_enc appears exactly 1 cycle after its x; asserting reset mid-stream -> 000 on that edge.
REQ-036 Random x against a reference-model comparison (including ±0, ±Inf, NaN, subnormals) -> bit-exact x_enc match every cycle.
